// File: rtl/mux8_1_if.sv
// Signal bundle for one mux8_1 lane selector: data lanes, select, capture
// enable and both result views. The master drives data/select/enable; the
// slave view is what a mux8_1 sees.
interface mux8_1_if #(
  parameter int WIDTH = 1
);
  logic [8*WIDTH-1:0] in;
  logic [2:0]         s;
  logic               en;
  logic [WIDTH-1:0]   out;
  logic [WIDTH-1:0]   out_q;

  modport master (
    output in,
    output s,
    output en,
    input  out,
    input  out_q
  );

  modport slave (
    input  in,
    input  s,
    input  en,
    output out,
    output out_q
  );
endinterface

// File: rtl/mux8_1.sv
// 8:1 lane selector built from two 4:1 stages and a final 2:1 stage, with a
// registered copy of the selected lane. The ports stay plain so the block can
// serve as a purely combinational leaf of a wider tree (clk/reset_n/en tied
// off, only in/s/out used).

// 4:1 lane selector, purely combinational; lane k is in[k*WIDTH +: WIDTH].
module mux4_1 #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0]   out,
  input  logic [4*WIDTH-1:0] in,
  input  logic [1:0]         s
);

  // Pick one of four lanes by s.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives out, so no latch is inferred.
    out = '0;
    unique case (s)
      2'd0: out = in[0*WIDTH +: WIDTH];
      2'd1: out = in[1*WIDTH +: WIDTH];
      2'd2: out = in[2*WIDTH +: WIDTH];
      2'd3: out = in[3*WIDTH +: WIDTH];
      default: out = '0;
    endcase
  end

endmodule

module mux8_1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [8*WIDTH-1:0] in,
  input  logic [2:0]         s,
  input  logic               en,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q
);

  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] upper;

  // Lanes 0-3 and lanes 4-7, each selected by the low two select bits.
  mux4_1 #(.WIDTH(WIDTH)) u_lower (
    .out (lower),
    .in  (in[4*WIDTH-1:0]),
    .s   (s[1:0])
  );

  mux4_1 #(.WIDTH(WIDTH)) u_upper (
    .out (upper),
    .in  (in[8*WIDTH-1:4*WIDTH]),
    .s   (s[1:0])
  );

  // Final 2:1 stage: s[2] chooses between the lower and upper groups.
  always_comb begin
    out = s[2] ? upper : lower;
  end

  // Capture the selected lane when enabled; reset clears it at once.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      out_q <= '0;
    end else if (en) begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux8_1.sv
// Directed self-checking bench for mux8_1 (WIDTH=1 via the interface, plus a
// WIDTH=4 instance for lane slicing) and a standalone mux4_1.
module tb_mux8_1;

  logic clk;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  mux8_1_if #(.WIDTH(1)) bus ();

  mux8_1 #(.WIDTH(1)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bus.in),
    .s       (bus.s),
    .en      (bus.en),
    .out     (bus.out),
    .out_q   (bus.out_q)
  );

  // Wider instance to exercise lane slicing with WIDTH > 1.
  logic [31:0] in4;
  logic [2:0]  s4;
  logic [3:0]  out4;
  logic [3:0]  out4_q;

  mux8_1 #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in4),
    .s       (s4),
    .en      (1'b0),
    .out     (out4),
    .out_q   (out4_q)
  );

  // Standalone 4:1 stage.
  logic [3:0] m4_in;
  logic [1:0] m4_s;
  logic       m4_out;

  mux4_1 #(.WIDTH(1)) u_m4 (
    .out (m4_out),
    .in  (m4_in),
    .s   (m4_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] s;
    logic [7:0] in;
    logic       exp;
  } vec_t;

  vec_t vecs[8] = '{
    '{3'd0, 8'h01, 1'b1},
    '{3'd0, 8'h02, 1'b0},
    '{3'd1, 8'h02, 1'b1},
    '{3'd1, 8'h01, 1'b0},
    '{3'd4, 8'h10, 1'b1},
    '{3'd4, 8'h01, 1'b0},
    '{3'd7, 8'h80, 1'b1},
    '{3'd7, 8'h00, 1'b0}
  };

  initial begin
    reset_n = 1'b0;
    bus.in  = 8'h00;
    bus.s   = 3'd0;
    bus.en  = 1'b0;
    in4     = 32'h0;
    s4      = 3'd0;
    m4_in   = 4'b0;
    m4_s    = 2'd0;

    // Reset state without any clock edge (first rising edge is at t=5).
    #1;
    check("reset_out_q_no_edge", {31'b0, bus.out_q}, 32'd0);

    // Combinational path live during reset.
    bus.s = 3'd3; bus.in = 8'h08;
    #1;
    check("out_during_reset", {31'b0, bus.out}, 32'd1);

    // Directed combinational vectors.
    foreach (vecs[i]) begin
      bus.s  = vecs[i].s;
      bus.in = vecs[i].in;
      #1;
      check($sformatf("dir_s%0d_in%02h", vecs[i].s, vecs[i].in), {31'b0, bus.out}, {31'b0, vecs[i].exp});
    end

    // Exhaustive WIDTH=1 sweep.
    for (int si = 0; si < 8; si++) begin
      for (int ii = 0; ii < 256; ii++) begin
        logic [7:0] v;
        v = ii[7:0];
        bus.s  = si[2:0];
        bus.in = v;
        #1;
        check($sformatf("exh_s%0d_in%02h", si, ii), {31'b0, bus.out}, {31'b0, v[si]});
      end
    end

    // WIDTH=4 lane slicing: lane k holds nibble value k+8 style pattern.
    in4 = 32'hFEDC_BA98;
    for (int k = 0; k < 8; k++) begin
      s4 = k[2:0];
      #1;
      check($sformatf("w4_lane%0d", k), {28'b0, out4}, 32'd8 + k);
    end

    // Standalone mux4_1.
    m4_s = 2'd2; m4_in = 4'b0100;
    #1;
    check("m4_s2_0100", {31'b0, m4_out}, 32'd1);
    m4_in = 4'b1011;
    #1;
    check("m4_s2_1011", {31'b0, m4_out}, 32'd0);
    m4_s = 2'd3;
    #1;
    check("m4_s3_1011", {31'b0, m4_out}, 32'd1);

    // Registered path: release reset between edges, set up capture.
    @(negedge clk);
    reset_n = 1'b1;
    bus.en = 1'b1; bus.s = 3'd3; bus.in = 8'h08;
    #1;
    check("out_q_before_edge", {31'b0, bus.out_q}, 32'd0);
    @(posedge clk); #1;
    check("out_q_first_capture", {31'b0, bus.out_q}, 32'd1);

    // Hold with en=0.
    @(negedge clk);
    bus.en = 1'b0; bus.in = 8'h00;
    #1;
    check("out_after_in_clear", {31'b0, bus.out}, 32'd0);
    check("out_q_hold_pre", {31'b0, bus.out_q}, 32'd1);
    @(posedge clk); #1;
    check("out_q_hold_edge", {31'b0, bus.out_q}, 32'd1);

    // Capture a zero with en=1.
    bus.en = 1'b1;
    @(posedge clk); #1;
    check("out_q_capture_zero", {31'b0, bus.out_q}, 32'd0);
    bus.in = 8'h08;
    @(posedge clk); #1;
    check("out_q_recapture_one", {31'b0, bus.out_q}, 32'd1);

    // Reset mid-operation between edges.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_reset_out_q", {31'b0, bus.out_q}, 32'd0);
    check("mid_reset_out", {31'b0, bus.out}, 32'd1);
    bus.s = 3'd2;
    #1;
    check("mid_reset_out_track", {31'b0, bus.out}, 32'd0);
    bus.s = 3'd3;
    @(posedge clk); #1;
    check("reset_held_edge", {31'b0, bus.out_q}, 32'd0);

    // Release with en=0: stays 0 until a capture.
    @(negedge clk);
    reset_n = 1'b1; bus.en = 1'b0;
    @(posedge clk); #1;
    check("post_reset_no_en", {31'b0, bus.out_q}, 32'd0);
    bus.en = 1'b1;
    @(posedge clk); #1;
    check("post_reset_capture", {31'b0, bus.out_q}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
